// File: rtl/i2s_slave_pkg.sv
// Shared constants, FSM encodings and payload types for the I2S slave.
package i2s_slave_pkg;
  localparam int unsigned RX_WIDTH    = 24;
  localparam int unsigned TX_WIDTH    = 16;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = $clog2(SLOT_BITS + 2);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_LEFT   = 2'd1;
  localparam logic [1:0] ST_RIGHT  = 2'd2;

  localparam logic LR_LEFT = 1'b0;

  typedef struct packed {
    logic [TX_WIDTH-1:0] re;
    logic [TX_WIDTH-1:0] im;
  } tx_pair_t;
endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-stage synchroniser for an asynchronous input followed by a registered
// edge detector; level, rise and fall leave together on the same cycle.
module i2s_edge_sync
  import i2s_slave_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      level  <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~level;
      fall   <= ~sync_q[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/i2s_slave.sv
// Codec-side I2S slave: oversampled BCLK/LRCLK/SD, 24-bit RX pair deserialiser,
// 16-bit TX pair serialiser with a shadow/hold double buffer.
module i2s_slave
  import i2s_slave_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk_in,
  input  logic                lrclk_in,
  input  logic                sd_in,
  output logic                sd_out,
  input  logic [TX_WIDTH-1:0] tx_real,
  input  logic [TX_WIDTH-1:0] tx_imag,
  input  logic                tx_valid,
  output logic                tx_underrun,
  output logic [RX_WIDTH-1:0] rx_real,
  output logic [RX_WIDTH-1:0] rx_imag,
  output logic                rx_valid,
  output logic                locked,
  output logic                frame_err
);
  logic bclk_rise, bclk_fall, bclk_lvl_unused;
  logic lr_s, lr_rise_unused, lr_fall_unused;
  logic [SYNC_STAGES:0] sd_pipe;
  logic sd_s;

  logic [1:0]          state, state_next;
  logic                lr_prev, lr_chg, slot_ok;
  logic [CNT_W-1:0]    bit_cnt, cnt_inc;
  logic [RX_WIDTH-1:0] rx_sr, left_hold;
  logic [TX_WIDTH-2:0] tx_sr;
  logic [TX_WIDTH-1:0] hold_imag;
  tx_pair_t            shadow;
  logic                fresh, rx_pend;

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk(clk), .reset(reset), .d(bclk_in),
    .level(bclk_lvl_unused), .rise(bclk_rise), .fall(bclk_fall)
  );

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk (
    .clk(clk), .reset(reset), .d(lrclk_in),
    .level(lr_s), .rise(lr_rise_unused), .fall(lr_fall_unused)
  );

  // Data takes the synchroniser plus edge-flop depth so it lines up with the strobes.
  always_ff @(posedge clk) begin
    if (reset) sd_pipe <= '0;
    else       sd_pipe <= {sd_pipe[SYNC_STAGES-1:0], sd_in};
  end
  assign sd_s = sd_pipe[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_UNSYNC;
    else       state <= state_next;
  end

  // The rise carrying an LR change is the last bit of the old slot, so it is counted there.
  always_comb begin
    lr_chg     = bclk_rise && (lr_s != lr_prev);
    cnt_inc    = (bit_cnt == CNT_W'(SLOT_BITS + 1)) ? bit_cnt : bit_cnt + CNT_W'(1);
    slot_ok    = (cnt_inc == CNT_W'(SLOT_BITS));
    state_next = state;
    if (lr_chg) begin
      case (state)
        ST_UNSYNC: if (lr_s == LR_LEFT) state_next = ST_LEFT;
        ST_LEFT:   state_next = slot_ok ? ST_RIGHT : ST_UNSYNC;
        ST_RIGHT:  state_next = slot_ok ? ST_LEFT : ST_UNSYNC;
        default:   state_next = ST_UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_prev     <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      left_hold   <= '0;
      rx_real     <= '0;
      rx_imag     <= '0;
      rx_pend     <= 1'b0;
      rx_valid    <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
      tx_sr       <= '0;
      hold_imag   <= '0;
      shadow      <= '0;
      fresh       <= 1'b0;
      tx_underrun <= 1'b0;
      sd_out      <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      rx_pend     <= 1'b0;
      rx_valid    <= rx_pend;

      if (bclk_rise) begin
        lr_prev <= lr_s;
        if (bit_cnt < CNT_W'(RX_WIDTH)) rx_sr <= {rx_sr[RX_WIDTH-2:0], sd_s};
        bit_cnt <= lr_chg ? '0 : cnt_inc;
        if (lr_chg && state != ST_UNSYNC) begin
          if (!slot_ok) begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
          end else begin
            locked <= 1'b1;
            if (state == ST_LEFT) begin
              left_hold <= rx_sr;
            end else begin
              rx_real <= left_hold;
              rx_imag <= rx_sr;
              rx_pend <= 1'b1;
            end
          end
        end
      end

      // A write coinciding with a left load lands after the load reads the old shadow.
      if (tx_valid) begin
        shadow.re <= tx_real;
        shadow.im <= tx_imag;
        fresh     <= 1'b1;
      end

      if (bclk_fall) begin
        if (state == ST_UNSYNC) begin
          tx_sr  <= '0;
          sd_out <= 1'b0;
        end else if (bit_cnt == '0 && state == ST_LEFT) begin
          hold_imag <= shadow.im;
          tx_sr     <= shadow.re[TX_WIDTH-2:0];
          sd_out    <= shadow.re[TX_WIDTH-1];
          if (!tx_valid) fresh <= 1'b0;
          if (!fresh) tx_underrun <= 1'b1;
        end else if (bit_cnt == '0) begin
          tx_sr  <= hold_imag[TX_WIDTH-2:0];
          sd_out <= hold_imag[TX_WIDTH-1];
        end else begin
          tx_sr  <= {tx_sr[TX_WIDTH-3:0], 1'b0};
          sd_out <= tx_sr[TX_WIDTH-2];
        end
      end
    end
  end
endmodule
